// File: rtl/jtpang_busak.sv
// Z80-side bus arbiter: grants the video object DMA the VRAM/attr bus at machine-cycle
// boundaries, stalling the CPU while DMA owns the bus.
module jtpang_busak #(
    parameter logic [11:0] MAXHOLD = 12'd2048,
    parameter logic [3:0]  MINGAP  = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cen,
    input  logic        busrq,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    output logic        busak_n,
    output logic        cpu_cen_g,
    output logic        dma_sel,
    output logic        hold_err,
    output logic [11:0] grant_cnt
);

    localparam int unsigned CW = 12;
    localparam int unsigned GW = 4;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 12'd1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] hold_cnt, hold_nx, grant_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic          busak_nx, dma_nx, err_nx;
    logic          boundary;

    // A fetch cycle (m1_n low) is never split, even with both strobes idle
    assign boundary  = mreq_n & iorq_n & m1_n;
    assign cpu_cen_g = cpu_cen & ~((state == ST_GRANT) | (state == ST_RELEASE));

    // Next-state and registered-output logic; nothing moves without cpu_cen
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        gap_nx   = gap_cnt;
        grant_nx = grant_cnt;
        busak_nx = busak_n;
        dma_nx   = dma_sel;
        err_nx   = hold_err;
        if (cpu_cen) begin
            case (state)
                ST_IDLE: begin
                    if (gap_cnt < MINGAP) begin
                        gap_nx = gap_cnt + 4'd1;
                    end else if (busrq) begin
                        state_nx = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!busrq) begin
                        state_nx = ST_IDLE;
                    end else if (boundary) begin
                        state_nx = ST_GRANT;
                        dma_nx   = 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != CNT_MAX) begin
                        hold_nx = hold_cnt + 12'd1;
                    end
                    if (!busrq) begin
                        state_nx = ST_RELEASE;
                        busak_nx = 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nx = ST_RELEASE;
                        busak_nx = 1'b1;
                        err_nx   = 1'b1;
                    end else begin
                        busak_nx = 1'b0;
                    end
                end
                ST_RELEASE: begin
                    grant_nx = hold_cnt;
                    hold_nx  = '0;
                    gap_nx   = '0;
                    dma_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= MINGAP;
            grant_cnt <= '0;
            busak_n   <= 1'b1;
            dma_sel   <= 1'b0;
            hold_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            gap_cnt   <= gap_nx;
            grant_cnt <= grant_nx;
            busak_n   <= busak_nx;
            dma_sel   <= dma_nx;
            hold_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_jtpang_busak.sv
// Bench for jtpang_busak: two instances (default MAXHOLD and MAXHOLD=16) checked against
// a transaction-level model, with directed scenarios followed by random traffic.
module tb_jtpang_busak;

    localparam int MH_A = 2048;
    localparam int MH_B = 16;
    localparam int MG   = 2;
    localparam int P_IDLE = 0, P_WAIT = 1, P_GRANT = 2, P_REL = 3;

    logic clk = 1'b0, rst_n = 1'b1;
    logic cpu_cen = 1'b0, busrq = 1'b0, mreq_n = 1'b1, iorq_n = 1'b1, m1_n = 1'b1;
    logic a_busak_n, a_cen_g, a_dma_sel, a_hold_err;
    logic b_busak_n, b_cen_g, b_dma_sel, b_hold_err;
    logic [11:0] a_grant_cnt, b_grant_cnt;

    jtpang_busak dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .busrq(busrq),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n),
        .busak_n(a_busak_n), .cpu_cen_g(a_cen_g), .dma_sel(a_dma_sel),
        .hold_err(a_hold_err), .grant_cnt(a_grant_cnt)
    );

    jtpang_busak #(.MAXHOLD(12'd16)) dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .busrq(busrq),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n),
        .busak_n(b_busak_n), .cpu_cen_g(b_cen_g), .dma_sel(b_dma_sel),
        .hold_err(b_hold_err), .grant_cnt(b_grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int hold;
        int gap;
        int gcnt;
        bit bk_n;
        bit dma;
        bit err;
    } mdl_t;

    mdl_t ma, mb;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph = P_IDLE; m.hold = 0; m.gap = MG; m.gcnt = 0;
        m.bk_n = 1'b1; m.dma = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    // One cpu_cen tick of the arbitration rules
    function automatic mdl_t step(input mdl_t m, input bit rq, input bit bnd, input int maxhold);
        mdl_t n = m;
        if (m.ph == P_IDLE) begin
            if (m.gap >= MG && rq) n.ph = P_WAIT;
            n.gap = (m.gap + 1 > MG) ? MG : m.gap + 1;
        end else if (m.ph == P_WAIT) begin
            if (!rq) n.ph = P_IDLE;
            else if (bnd) begin n.ph = P_GRANT; n.dma = 1'b1; end
        end else if (m.ph == P_GRANT) begin
            n.hold = (m.hold >= 4095) ? 4095 : m.hold + 1;
            if (!rq || m.hold + 1 == maxhold) begin
                n.ph = P_REL;
                n.bk_n = 1'b1;
                if (rq) n.err = 1'b1;
            end else begin
                n.bk_n = 1'b0;
            end
        end else begin
            n.gcnt = m.hold; n.hold = 0; n.gap = 0; n.dma = 1'b0; n.ph = P_IDLE;
        end
        return n;
    endfunction

    task automatic cmp_all();
        check("a_busak_n", a_busak_n, ma.bk_n);
        check("a_dma_sel", a_dma_sel, ma.dma);
        check("a_hold_err", a_hold_err, ma.err);
        check("a_grant_cnt", a_grant_cnt, ma.gcnt);
        check("a_cen_g", a_cen_g, cpu_cen & !(ma.ph == P_GRANT || ma.ph == P_REL));
        check("b_busak_n", b_busak_n, mb.bk_n);
        check("b_dma_sel", b_dma_sel, mb.dma);
        check("b_hold_err", b_hold_err, mb.err);
        check("b_grant_cnt", b_grant_cnt, mb.gcnt);
        check("b_cen_g", b_cen_g, cpu_cen & !(mb.ph == P_GRANT || mb.ph == P_REL));
    endtask

    // Called at a negedge; leaves the bench at the next negedge after checking
    task automatic tick(input bit cen, input bit rq, input bit mq, input bit iq, input bit m1);
        cpu_cen = cen; busrq = rq; mreq_n = mq; iorq_n = iq; m1_n = m1;
        @(posedge clk);
        if (cen) begin
            ma = step(ma, rq, mq & iq & m1, MH_A);
            mb = step(mb, rq, mq & iq & m1, MH_B);
        end
        @(negedge clk);
        cmp_all();
    endtask

    // Asserted between edges so the outputs must clear without a clock
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check("rst_busak_n", a_busak_n, 1);
        check("rst_dma_sel", a_dma_sel, 0);
        check("rst_hold_err", a_hold_err, 0);
        check("rst_grant_cnt", a_grant_cnt, 0);
        cmp_all();
        @(negedge clk);
        cmp_all();
        rst_n = 1'b1;
    endtask

    initial begin
        bit rq;
        @(negedge clk);
        do_reset();

        // Idle bus: dma_sel after 2 cen, busak_n after 3; B is force-released at 16
        tick(1, 1, 1, 1, 1);
        check("t1_dma_cen1", a_dma_sel, 0);
        tick(1, 1, 1, 1, 1);
        check("t1_dma_cen2", a_dma_sel, 1);
        check("t1_busak_cen2", a_busak_n, 1);
        tick(1, 1, 1, 1, 1);
        check("t1_busak_cen3", a_busak_n, 0);
        check("t1_cen_g_cen3", a_cen_g, 0);
        for (int i = 4; i <= 301; i++) begin
            tick(1, 1, 1, 1, 1);
            if (i == 18) begin
                check("tb_forced_busak", b_busak_n, 1);
                check("tb_forced_err", b_hold_err, 1);
                check("tb_forced_dma", b_dma_sel, 1);
            end
            if (i == 19) begin
                check("tb_grant_cnt", b_grant_cnt, 16);
                check("tb_dma_off", b_dma_sel, 0);
            end
            if (i == 22) check("tb_gap_nodma", b_dma_sel, 0);
            if (i == 23) check("tb_regrant_dma", b_dma_sel, 1);
        end
        tick(1, 0, 1, 1, 1);
        check("t1_rel_busak", a_busak_n, 1);
        check("t1_rel_dma", a_dma_sel, 1);
        check("t1_rel_cen_g", a_cen_g, 0);
        check("t1_rel_err", a_hold_err, 0);
        tick(1, 1, 1, 1, 1);
        check("t1_grant_cnt", a_grant_cnt, 300);
        check("t1_idle_dma", a_dma_sel, 0);
        check("t1_idle_cen_g", a_cen_g, 1);
        tick(1, 1, 1, 1, 1);
        tick(1, 1, 1, 1, 1);
        tick(1, 1, 1, 1, 1);
        check("t1_gap_nodma", a_dma_sel, 0);
        tick(1, 1, 1, 1, 1);
        check("t1_regrant_dma", a_dma_sel, 1);

        // Memory cycle in progress, then an opcode fetch, hold off the grant
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 0, 1, 1);
            check("t2_busak_mreq", a_busak_n, 1);
            check("t2_dma_mreq", a_dma_sel, 0);
        end
        tick(0, 1, 1, 1, 1);
        check("t2_no_cen", a_dma_sel, 0);
        tick(1, 1, 1, 1, 0);
        check("t2_m1_dma", a_dma_sel, 0);
        tick(1, 1, 1, 1, 1);
        check("t2_dma", a_dma_sel, 1);
        check("t2_busak_pre", a_busak_n, 1);
        tick(1, 1, 1, 1, 1);
        check("t2_busak", a_busak_n, 0);

        // One-tick request dropped in WAIT never reaches the bus
        do_reset();
        tick(1, 1, 0, 1, 1);
        tick(1, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 1, 1, 1);
            check("t3_busak", a_busak_n, 1);
            check("t3_dma", a_dma_sel, 0);
        end

        // Reset in the middle of a grant
        do_reset();
        tick(1, 1, 1, 1, 1);
        tick(1, 1, 1, 1, 1);
        tick(1, 1, 1, 1, 1);
        check("t4_busak_pre", a_busak_n, 0);
        do_reset();

        // Random traffic
        rq = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(39) == 0) rq = ~rq;
            if ($urandom_range(1999) == 0) do_reset();
            tick($urandom_range(2) != 0, rq, $urandom_range(1) != 0,
                 $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
